// File: rtl/ram_program_loader_pkg.sv
// Shared definitions for the RAM program loader.
// Contents:
//   DATA_WIDTH            machine word / stream byte width
//   LOADER_MAGIC_DEFAULT  default frame start byte
//   loader_state_t        loader FSM state encoding
//   sum_zero()            true when two bytes add to zero modulo 2**DATA_WIDTH
package ram_program_loader_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam logic [DATA_WIDTH-1:0] LOADER_MAGIC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCsum,
        StVerify,
        StDone,
        StError
    } loader_state_t;

    function automatic logic sum_zero(input logic [DATA_WIDTH-1:0] a,
                                      input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] t;
        t = a + b;
        return t == '0;
    endfunction

endpackage

// File: rtl/ram_program_loader_if.sv
// Valid/ready byte stream feeding the program loader.
// Signals:
//   in_data   stream byte
//   in_valid  in_data valid (producer holds the byte until accepted)
//   in_ready  consumer accepts the byte this cycle
// Modports: master = byte producer, slave = loader.
interface ram_program_loader_if;
    import ram_program_loader_pkg::*;

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/ram_program_loader.sv
// Byte-stream boot loader in front of the computer's RAM.
// Receives a frame MAGIC, LEN, LEN data bytes, CSUM; writes the data to RAM from address 0 and
// keeps the CPU in reset until an image with (LEN + sum(data) + CSUM) mod 256 == 0 is resident.
// Optional feature: define LOADER_READBACK_EN to re-read the image from RAM and re-check the
// checksum before releasing the CPU. Without it ram_re is tied 0 and ram_rdata is ignored.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   stream (slave)   in_data / in_valid / in_ready byte stream
//   rearm            1-cycle pulse: leave DONE/ERROR, return to IDLE
//   ram_we/addr/wdata  RAM write port (1-cycle pulse per data byte)
//   ram_re, ram_rdata  RAM read port used only by readback verify
//   cpu_hold         1 = hold CPU in reset (flop-driven)
//   load_done        image loaded and verified
//   load_error       frame rejected; sticky until rearm/reset
module ram_program_loader
    import ram_program_loader_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 4,
    parameter logic [DATA_WIDTH-1:0] LOADER_MAGIC = LOADER_MAGIC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ram_program_loader_if.slave   stream,
    input  logic                  rearm,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    // Counters are one bit wider than the address so LEN == capacity is representable.
    localparam int unsigned           CW       = ADDR_WIDTH + 1;
    localparam logic [DATA_WIDTH-1:0] CAP_BYTE = DATA_WIDTH'(2 ** ADDR_WIDTH);

    loader_state_t state_q, state_d;

    logic                  in_ready_q, in_ready_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;

    logic xfer;
    logic len_bad;
    logic last_data;
    logic csum_good;

    // in_ready is a flop; it only differs from "state accepts" in the first cycle after reset.
    assign xfer      = stream.in_valid & in_ready_q;
    assign len_bad   = (stream.in_data == '0) || (stream.in_data > CAP_BYTE);
    assign last_data = (ptr_q + CW'(1)) == count_q;
    assign csum_good = sum_zero(sum_q, stream.in_data);

`ifdef LOADER_READBACK_EN
    logic                  ram_re_q, ram_re_d;
    logic                  rd_pend_q;
    logic [CW-1:0]         rcv_q, rcv_d;
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    logic                  verify_end;

    assign verify_end = (rcv_q == count_q);
`endif

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (xfer && (stream.in_data == LOADER_MAGIC)) state_d = StLen;
            end
            StLen: begin
                if (xfer) state_d = len_bad ? StError : StData;
            end
            StData: begin
                if (xfer && last_data) state_d = StCsum;
            end
            StCsum: begin
                if (xfer) begin
                    if (!csum_good) begin
                        state_d = StError;
                    end else begin
`ifdef LOADER_READBACK_EN
                        state_d = StVerify;
`else
                        state_d = StDone;
`endif
                    end
                end
            end
`ifdef LOADER_READBACK_EN
            StVerify: begin
                if (verify_end) state_d = sum_zero(sum_q, csum_q) ? StDone : StError;
            end
`endif
            StDone, StError: begin
                if (rearm) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- outputs / datapath
    always_comb begin
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        count_d      = count_q;
        ptr_d        = ptr_q;
        sum_d        = sum_q;
        // Flags follow the state being entered so they change on the same edge as the state.
        in_ready_d   = state_d inside {StIdle, StLen, StData, StCsum};
        cpu_hold_d   = (state_d != StDone);
        load_done_d  = (state_d == StDone);
        load_error_d = (state_d == StError);
`ifdef LOADER_READBACK_EN
        ram_re_d     = 1'b0;
        rcv_d        = rcv_q;
        csum_d       = csum_q;
`endif
        unique case (state_q)
            StLen: begin
                if (xfer) begin
                    count_d = stream.in_data[CW-1:0];
                    ptr_d   = '0;
                    sum_d   = stream.in_data;
                end
            end
            StData: begin
                if (xfer) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = ptr_q[ADDR_WIDTH-1:0];
                    ram_wdata_d = stream.in_data;
                    ptr_d       = ptr_q + CW'(1);
                    sum_d       = sum_q + stream.in_data;
                end
            end
`ifdef LOADER_READBACK_EN
            StCsum: begin
                if (xfer) begin
                    csum_d = stream.in_data;
                    ptr_d  = '0;
                    rcv_d  = '0;
                    sum_d  = DATA_WIDTH'(count_q);
                end
            end
            StVerify: begin
                if (ptr_q < count_q) begin
                    ram_re_d   = 1'b1;
                    ram_addr_d = ptr_q[ADDR_WIDTH-1:0];
                    ptr_d      = ptr_q + CW'(1);
                end
                // Read data arrives the cycle after the registered strobe.
                if (rd_pend_q) begin
                    sum_d = sum_q + ram_rdata;
                    rcv_d = rcv_q + CW'(1);
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_q   <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            count_q      <= '0;
            ptr_q        <= '0;
            sum_q        <= '0;
        end else begin
            in_ready_q   <= in_ready_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            count_q      <= count_d;
            ptr_q        <= ptr_d;
            sum_q        <= sum_d;
        end
    end

`ifdef LOADER_READBACK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_re_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            rcv_q     <= '0;
            csum_q    <= '0;
        end else begin
            ram_re_q  <= ram_re_d;
            rd_pend_q <= ram_re_q;
            rcv_q     <= rcv_d;
            csum_q    <= csum_d;
        end
    end

    assign ram_re = ram_re_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^ram_rdata;
    assign ram_re       = 1'b0;
`endif

    assign stream.in_ready = in_ready_q;
    assign ram_we          = ram_we_q;
    assign ram_addr        = ram_addr_q;
    assign ram_wdata       = ram_wdata_q;
    assign cpu_hold        = cpu_hold_q;
    assign load_done       = load_done_q;
    assign load_error      = load_error_q;

endmodule
